// File: rtl/command_word_assembler_if.sv
// command_word_assembler_if: command FIFO read port plus the command strobe/word
// bus that fans out to the per-field decoders.
interface command_word_assembler_if;
  logic        FifoEmpty;
  logic [7:0]  FifoData;
  logic        FifoRdEn;
  logic        CommandEn;
  logic [15:0] CommandWord;
  logic        TimeoutError;
  logic [15:0] CommandCount;
  modport master (
    output FifoEmpty, FifoData,
    input  FifoRdEn, CommandEn, CommandWord, TimeoutError, CommandCount
  );
  modport slave (
    input  FifoEmpty, FifoData,
    output FifoRdEn, CommandEn, CommandWord, TimeoutError, CommandCount
  );
endinterface

// File: rtl/command_word_assembler.sv
// command_word_assembler: packs FIFO byte pairs (high byte first) into 16-bit
// command words, dropping a half word when the low byte is too late.
module command_word_assembler #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input logic Clk,
  input logic reset,
  command_word_assembler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_HI, GET_LO, WAIT_LO} state_e;
  state_e      state_q, state_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] timer_q, timer_d, word_q, word_d, cnt_q, cnt_d;
  logic        en_q, en_d, to_q, to_d, rd_en, expire;
  // A zero timeout never expires, so a half word may wait forever.
  assign expire = TIMEOUT_CYCLES != 16'd0 && timer_q == TIMEOUT_CYCLES - 16'd1;
  always_ff @(posedge Clk) state_q <= reset ? IDLE : state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = bus.FifoEmpty ? IDLE : WAIT_HI;
      WAIT_HI: state_d = GET_LO;
      GET_LO:  state_d = !bus.FifoEmpty ? WAIT_LO : expire ? IDLE : GET_LO;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rd_en   = ~reset & ~bus.FifoEmpty & (state_q == IDLE | state_q == GET_LO);
    hi_d    = state_q == WAIT_HI ? bus.FifoData : hi_q;
    timer_d = state_q == WAIT_HI ? 16'd0 :
              (state_q == GET_LO && timer_q != 16'hFFFF) ? timer_q + 16'd1 : timer_q;
    en_d    = state_q == WAIT_LO;
    to_d    = state_q == GET_LO & bus.FifoEmpty & expire;
    word_d  = en_d ? {hi_q, bus.FifoData} : word_q;
    cnt_d   = cnt_q + {15'd0, en_d};
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      hi_q    <= 8'd0;
      timer_q <= 16'd0;
      word_q  <= 16'd0;
      cnt_q   <= 16'd0;
      en_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      timer_q <= timer_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      to_q    <= to_d;
    end
  end
  assign bus.FifoRdEn     = rd_en;
  assign bus.CommandEn    = en_q;
  assign bus.CommandWord  = word_q;
  assign bus.TimeoutError = to_q;
  assign bus.CommandCount = cnt_q;
endmodule

// File: tb/tb_command_word_assembler.sv
// tb_command_word_assembler: table vectors, corner sequences and a random byte
// stream scored against an arrival-time model of the assembler.
module tb_command_word_assembler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  command_word_assembler_if b0 ();
  command_word_assembler_if b1 ();
  command_word_assembler #(.TIMEOUT_CYCLES(16'd10)) dut0 (.Clk(clk), .reset(rst), .bus(b0));
  command_word_assembler #(.TIMEOUT_CYCLES(16'd0))  dut1 (.Clk(clk), .reset(rst), .bus(b1));
  typedef struct {int c; logic [15:0] w;} ev_t;
  typedef struct {
    int n; logic [0:5][7:0] b; logic [0:5][15:0] av;
    int nw; logic [0:2][15:0] w; logic [0:2][15:0] wc;
    int nt; int tc; logic [15:0] cnt;
  } vec_t;
  ev_t got_w[$], exp_w[$];
  int got_t[$], exp_t[$];
  logic [7:0] bytes [32];
  int avail [32];
  int cyc = 0, n = 0, popped = 0, sel = 0, viol = 0, total = 0, passed = 0;
  logic [15:0] prev_w;
  logic prev_rst = 1'b1;
  vec_t v [6];
  initial begin
    b0.FifoEmpty = 1'b1; b1.FifoEmpty = 1'b1;
    b0.FifoData = 8'd0;  b1.FifoData = 8'd0;
  end
  function automatic int mx(int a, int b);
    return a > b ? a : b;
  endfunction
  function automatic vec_t mkv(int nn, logic [0:5][7:0] b, logic [0:5][15:0] av, int nw,
                               logic [0:2][15:0] w, logic [0:2][15:0] wc, int nt, int tc,
                               logic [15:0] cnt);
    vec_t r;
    r.n = nn; r.b = b; r.av = av; r.nw = nw; r.w = w; r.wc = wc; r.nt = nt; r.tc = tc; r.cnt = cnt;
    return r;
  endfunction
  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
  endtask
  task automatic refresh();
    logic fe;
    fe = !(popped < n && avail[popped] <= cyc);
    b0.FifoEmpty = fe; b1.FifoEmpty = fe;
  endtask
  // One clock: sample the selected DUT mid-cycle, then play the FIFO for the next cycle.
  task automatic step();
    logic rd, en, to;
    logic [15:0] w;
    logic [7:0] fd;
    ev_t e;
    @(negedge clk);
    rd = sel != 0 ? b1.FifoRdEn : b0.FifoRdEn;
    en = sel != 0 ? b1.CommandEn : b0.CommandEn;
    to = sel != 0 ? b1.TimeoutError : b0.TimeoutError;
    w  = sel != 0 ? b1.CommandWord : b0.CommandWord;
    if (en) begin e.c = cyc; e.w = w; got_w.push_back(e); end
    if (to) got_t.push_back(cyc);
    if (en && to) viol++;
    if (!prev_rst && !en && w !== prev_w) viol++;
    prev_w = w;
    prev_rst = rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rd && popped < n) begin fd = bytes[popped]; popped++; end
    else fd = 8'($urandom);
    b0.FifoData = fd; b1.FifoData = fd;
    refresh();
  endtask
  task automatic do_reset();
    n = 0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic start_run();
    popped = 0;
    viol = 0;
    got_w.delete();
    got_t.delete();
    refresh();
  endtask
  // Reader timing from byte arrival times: high byte taken when the reader is free,
  // low byte no earlier than two cycles later, abandoned after t idle GET_LO cycles.
  task automatic model(int t, int start);
    int fr, k, th, tl;
    ev_t e;
    exp_w.delete();
    exp_t.delete();
    fr = start;
    k = 0;
    while (k < n) begin
      th = mx(fr, avail[k]);
      k++;
      tl = k < n ? mx(th + 2, avail[k]) : 32'h7fffffff;
      if (t != 0 && tl > th + 1 + t) begin
        exp_t.push_back(th + t + 2);
        fr = th + t + 2;
      end else if (k < n) begin
        e.c = tl + 2; e.w = {bytes[k-1], bytes[k]};
        exp_w.push_back(e);
        k++;
        fr = tl + 2;
      end
    end
  endtask
  task automatic compare(string tag, logic [15:0] cnt);
    chk({tag, " nwords"}, got_w.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      chk({tag, " word"}, 32'(got_w[i].w), 32'(exp_w[i].w));
      chk({tag, " word_cycle"}, got_w[i].c, exp_w[i].c);
    end
    chk({tag, " ntimeouts"}, got_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size() && i < got_t.size(); i++)
      chk({tag, " timeout_cycle"}, got_t[i], exp_t[i]);
    chk({tag, " count"}, 32'(sel != 0 ? b1.CommandCount : b0.CommandCount), 32'(cnt));
    chk({tag, " strobe_invariants"}, viol, 0);
  endtask
  initial begin
    int base, acc, endc;
    ev_t e;
    v[0] = mkv(2, {8'h12, 8'h34, 32'h0}, {16'd0, 16'd0, 64'd0}, 1,
               {16'h1234, 32'h0}, {16'd4, 32'd0}, 0, 0, 16'd1);
    v[1] = mkv(6, {8'hA0, 8'h01, 8'hA1, 8'h02, 8'hA2, 8'h03}, 96'd0, 3,
               {16'hA001, 16'hA102, 16'hA203}, {16'd4, 16'd8, 16'd12}, 0, 0, 16'd3);
    v[2] = mkv(3, {8'hFF, 8'hAB, 8'hCD, 24'h0}, {16'd0, 16'd30, 16'd30, 48'd0}, 1,
               {16'hABCD, 32'h0}, {16'd34, 32'd0}, 1, 12, 16'd1);
    v[3] = mkv(2, {8'hFF, 8'h11, 32'h0}, {16'd0, 16'd11, 64'd0}, 1,
               {16'hFF11, 32'h0}, {16'd13, 32'd0}, 0, 0, 16'd1);
    v[4] = mkv(3, {8'h99, 8'h11, 8'h22, 24'h0}, {16'd0, 16'd12, 16'd12, 48'd0}, 1,
               {16'h1122, 32'h0}, {16'd16, 32'd0}, 1, 12, 16'd1);
    v[5] = mkv(2, {8'h5A, 8'hC3, 32'h0}, {16'd0, 16'd7, 64'd0}, 1,
               {16'h5AC3, 32'h0}, {16'd9, 32'd0}, 0, 0, 16'd1);
    // Reset with a non-empty FIFO: no reads, all outputs cleared.
    n = 2; bytes[0] = 8'h12; bytes[1] = 8'h34; avail[0] = 0; avail[1] = 0;
    refresh();
    step();
    chk("rden_in_reset", 32'(b0.FifoRdEn), 0);
    step();
    step();
    chk("rden_in_reset2", 32'(b0.FifoRdEn), 0);
    chk("reset_en", 32'(b0.CommandEn), 0);
    chk("reset_word", 32'(b0.CommandWord), 0);
    chk("reset_timeout", 32'(b0.TimeoutError), 0);
    chk("reset_count", 32'(b0.CommandCount), 0);
    chk("reset_popped", popped, 0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      base = cyc;
      n = v[i].n;
      for (int j = 0; j < n; j++) begin
        bytes[j] = v[i].b[j];
        avail[j] = base + int'(v[i].av[j]);
      end
      exp_w.delete();
      exp_t.delete();
      for (int j = 0; j < v[i].nw; j++) begin
        e.c = base + int'(v[i].wc[j]); e.w = v[i].w[j];
        exp_w.push_back(e);
      end
      if (v[i].nt != 0) exp_t.push_back(base + v[i].tc);
      start_run();
      repeat (50) step();
      compare($sformatf("vec%0d", i), v[i].cnt);
    end
    // Reset while waiting for the low byte: the stale high byte must vanish.
    do_reset();
    base = cyc;
    n = 3; bytes[0] = 8'h77; bytes[1] = 8'h11; bytes[2] = 8'h22;
    avail[0] = base; avail[1] = 1000000; avail[2] = 1000000;
    start_run();
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midreset_en", 32'(b0.CommandEn), 0);
    chk("midreset_word", 32'(b0.CommandWord), 0);
    chk("midreset_timeout", 32'(b0.TimeoutError), 0);
    chk("midreset_count", 32'(b0.CommandCount), 0);
    base = cyc;
    avail[1] = base; avail[2] = base;
    refresh();
    got_w.delete(); got_t.delete(); viol = 0;
    exp_w.delete(); exp_t.delete();
    e.c = base + 4; e.w = 16'h1122;
    exp_w.push_back(e);
    repeat (20) step();
    compare("midreset", 16'd1);
    // Zero timeout: a 5000-cycle gap must still pair the bytes.
    sel = 1;
    do_reset();
    base = cyc;
    n = 2; bytes[0] = 8'h55; bytes[1] = 8'h66; avail[0] = base; avail[1] = base + 5000;
    exp_w.delete(); exp_t.delete();
    e.c = base + 5002; e.w = 16'h5566;
    exp_w.push_back(e);
    start_run();
    while (cyc < base + 5010) step();
    compare("no_timeout", 16'd1);
    sel = 0;
    // Count wrap: park the counter at its top value, then emit one word.
    do_reset();
    force dut0.cnt_q = 16'hFFFF;
    step();
    release dut0.cnt_q;
    chk("preload_count", 32'(b0.CommandCount), 32'hFFFF);
    base = cyc;
    n = 2; bytes[0] = 8'h12; bytes[1] = 8'h34; avail[0] = base; avail[1] = base;
    exp_w.delete(); exp_t.delete();
    e.c = base + 4; e.w = 16'h1234;
    exp_w.push_back(e);
    start_run();
    repeat (15) step();
    compare("wrap", 16'h0000);
    // Random arrival patterns against the timing model.
    for (int r = 0; r < 8; r++) begin
      do_reset();
      base = cyc;
      n = $urandom_range(6, 14);
      acc = 0;
      for (int j = 0; j < n; j++) begin
        acc += ($urandom_range(0, 2) == 0) ? $urandom_range(0, 24) : 0;
        bytes[j] = 8'($urandom);
        avail[j] = base + acc;
      end
      model(10, base);
      endc = base + acc + 20;
      if (exp_w.size() > 0) endc = mx(endc, exp_w[exp_w.size()-1].c + 10);
      if (exp_t.size() > 0) endc = mx(endc, exp_t[exp_t.size()-1] + 10);
      start_run();
      while (cyc < endc) step();
      compare($sformatf("rand%0d", r), 16'(exp_w.size()));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/command_word_assembler.md
Name: command_word_assembler

Overview:
- Reads the 8-bit host command byte stream from the USB command FIFO (standard FIFO, 1-cycle read latency).
- Packs byte pairs into 16-bit command words and presents them as a one-cycle CommandEn strobe with CommandWord.
- The strobe and word fan out to all per-field command decoders, which match CommandWord[15:4] against their address.
- A timeout discards a half-received word so the stream cannot stay byte-misaligned.

Parameters:
- TIMEOUT_CYCLES, 16'd1000: idle cycles allowed between high and low byte before the partial word is discarded. 0 disables the timeout. Legal range 0..65535.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- FifoEmpty  input  1  command FIFO empty flag.
- FifoData  input  8  FIFO read data, valid the cycle after FifoRdEn.
- FifoRdEn  output  1  FIFO read strobe, combinational.
- CommandEn  output  1  one-cycle strobe: CommandWord is valid.
- CommandWord  output  16  assembled word, held until the next word.
- TimeoutError  output  1  one-cycle pulse: partial word discarded.
- CommandCount  output  16  count of words emitted since reset; wraps.

Behaviour:
- Reset (synchronous, reset=1 at a rising edge):
  - State goes to IDLE; the high-byte register and timer are cleared.
  - CommandEn=0, CommandWord=16'h0000, TimeoutError=0, CommandCount=0.
  - FifoRdEn is forced 0 while reset=1.
  - Reset mid-word discards the partial byte. A byte read in the same cycle as reset is lost; this is accepted.
- Byte order: first byte goes to CommandWord[15:8], second byte to CommandWord[7:0].
- FifoRdEn = ~reset & ~FifoEmpty & (state==IDLE | state==GET_LO).
- States:
  - IDLE:
    - if ~FifoEmpty: read issued, go to WAIT_HI.
    - else stay.
  - WAIT_HI:
    - capture FifoData into the high register, clear timer, go to GET_LO (unconditional).
  - GET_LO:
    - if ~FifoEmpty: read issued, go to WAIT_LO.
    - else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: TimeoutError=1 next cycle, go to IDLE, high byte dropped.
    - else timer+1.
  - WAIT_LO:
    - at the edge: CommandWord <= {high, FifoData}, CommandEn <= 1, CommandCount+1, go to IDLE (unconditional).
- CommandEn and TimeoutError are registered, high for exactly one cycle, and never both high.
- CommandWord changes only on the edge that sets CommandEn.
- Latency:
  - High-byte read in cycle N and low byte immediately available: low-byte read in N+2, CommandEn high in N+4.
  - Maximum throughput: one word per 4 cycles.
  - In the CommandEn cycle the state is IDLE, so the next read may be issued in that same cycle.
- Timeout timing: with a continuously empty FIFO after the high byte, TimeoutError is high exactly TIMEOUT_CYCLES+1 cycles after the WAIT_HI cycle.
- FifoEmpty deasserting in the same cycle the timeout expires: the read wins and no timeout occurs.
- CommandCount: 16'hFFFF + 1 wraps to 16'h0000. It is not incremented on timeout.
- Timer is 16 bits and saturates; it cannot wrap for legal TIMEOUT_CYCLES.
- No backpressure from downstream: decoders accept every strobe.

Test Plan:
- After reset, FIFO holds 8'h12, 8'h34 → FifoRdEn pulses twice 2 cycles apart; CommandEn=1 for one cycle with CommandWord=16'h1234, exactly 4 cycles after the first FifoRdEn; CommandCount=1.
- FIFO holds 6 bytes A0 01 A1 02 A2 03 back-to-back → words 16'hA001, 16'hA102, 16'hA203, 4 cycles apart; CommandCount=3.
- TIMEOUT_CYCLES=10, single byte 8'hFF then FIFO empty → TimeoutError pulse 11 cycles after WAIT_HI, no CommandEn, CommandCount unchanged. Later bytes 8'hAB, 8'hCD → word 16'hABCD, confirming realignment.
- TIMEOUT_CYCLES=0, high byte 8'h55, low byte 8'h66 arriving 5000 cycles later → no TimeoutError; CommandWord=16'h5566.
- reset asserted for 1 cycle while in GET_LO after byte 8'h77, then bytes 8'h11, 8'h22 → all outputs 0 after reset; word 16'h1122 (not 16'h7711).
- Preload CommandCount to 16'hFFFF (65535 words via a fast-forward stream), one more word → CommandCount=16'h0000.
